axi4_stream_fifo: RTL and testbench



---
 rtl/axi4_stream_pkg.sv | 20 ++
 rtl/axi4_stream_if.sv | 28 ++
 rtl/axi4_stream_fifo_mem.sv | 27 ++
 rtl/axi4_stream_fifo.sv | 111 +++++++++++
 tb/tb_axi4_stream_fifo.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_pkg.sv
// Shared AXI4-Stream definitions: default beat record and FIFO width helper.
package axi4_stream_pkg;

  localparam int unsigned AXIS_DN = 1;
  localparam int unsigned AXIS_DW = 8;

  typedef logic [AXIS_DW-1:0] axis_dt_t;

  typedef struct packed {
    axis_dt_t [AXIS_DN-1:0] data;
    logic     [AXIS_DN-1:0] keep;
    logic                   last;
  } axis_beat_t;

  // Fill counter needs one extra bit so that full (2**aw) is representable.
  function automatic int unsigned fifo_cnt_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream interface; d = sink side (data in), s = source side (data out).
interface axi4_stream_if
  import axi4_stream_pkg::*;
#(
  parameter int unsigned DN = AXIS_DN,
  parameter type         DT = axis_dt_t
) (
  input logic ACLK,
  input logic ARESETn
);

  logic            TVALID;
  logic            TREADY;
  DT    [DN-1:0]   TDATA;
  logic [DN-1:0]   TKEEP;
  logic            TLAST;

  modport d (
    input  ACLK, ARESETn, TVALID, TDATA, TKEEP, TLAST,
    output TREADY
  );

  modport s (
    input  TREADY,
    output TVALID, TDATA, TKEEP, TLAST
  );

endinterface

// File: rtl/axi4_stream_fifo_mem.sv
// Beat storage for the stream FIFO: synchronous write, asynchronous read.
module axi4_stream_fifo_mem #(
  parameter int unsigned AW = 4,
  parameter int unsigned BW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [BW-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_stream_fifo.sv
// Synchronous first-word-fall-through AXI4-Stream FIFO with fill level and flush.
// Define AXI4_STREAM_FIFO_PKT_EN for store-and-forward packet mode.
module axi4_stream_fifo
  import axi4_stream_pkg::*;
#(
  parameter int unsigned DN = AXIS_DN,
  parameter type         DT = axis_dt_t,
  parameter int unsigned AW = 4,
  localparam int unsigned CW = fifo_cnt_width(AW)
) (
  axi4_stream_if.d       sti,
  axi4_stream_if.s       sto,
  input  logic           clr,
  output logic [CW-1:0]  cnt
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef struct packed {
    DT    [DN-1:0] data;
    logic [DN-1:0] keep;
    logic          last;
  } beat_t;

  localparam int unsigned BW = $bits(beat_t);

  logic [CW-1:0] wptr_q;
  logic [CW-1:0] rptr_q;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          valid;
  beat_t         in_beat;
  beat_t         rd_beat;
  beat_t         out_beat;
  logic [BW-1:0] rd_raw;

  assign cnt   = wptr_q - rptr_q;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  // No full-side bypass: a pop in the same cycle does not reopen TREADY.
  assign sti.TREADY = ~full & sti.ARESETn;

  assign push = sti.TVALID & sti.TREADY;
  assign pop  = valid & sto.TREADY;

  assign in_beat.data = sti.TDATA;
  assign in_beat.keep = sti.TKEEP;
  assign in_beat.last = sti.TLAST;

  axi4_stream_fifo_mem #(
    .AW (AW),
    .BW (BW)
  ) u_mem (
    .clk   (sti.ACLK),
    .we    (push & ~clr),
    .waddr (wptr_q[AW-1:0]),
    .wdata (in_beat),
    .raddr (rptr_q[AW-1:0]),
    .rdata (rd_raw)
  );

  assign rd_beat = rd_raw;

  // Pointers wrap naturally at CW bits; flush overrides any push/pop.
  always_ff @(posedge sti.ACLK) begin
    if (!sti.ARESETn || clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + CW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + CW'(1);
      end
    end
  end

`ifdef AXI4_STREAM_FIFO_PKT_EN
  logic [CW-1:0] pkt_q;

  // Number of complete packets (TLAST beats) currently held.
  always_ff @(posedge sti.ACLK) begin
    if (!sti.ARESETn || clr) begin
      pkt_q <= '0;
    end else begin
      unique case ({push & sti.TLAST, pop & rd_beat.last})
        2'b10:   pkt_q <= pkt_q + CW'(1);
        2'b01:   pkt_q <= pkt_q - CW'(1);
        default: pkt_q <= pkt_q;
      endcase
    end
  end

  // Full override releases an oversize packet instead of deadlocking.
  assign valid = ~empty & ((pkt_q != '0) | full);
`else
  assign valid = ~empty;
`endif

  assign out_beat = valid ? rd_beat : '0;

  assign sto.TVALID = valid;
  assign sto.TDATA  = out_beat.data;
  assign sto.TKEEP  = out_beat.keep;
  assign sto.TLAST  = out_beat.last;

endmodule

// File: tb/tb_axi4_stream_fifo.sv
// Self-checking bench for axi4_stream_fifo: queue model compared every cycle plus literal pins.
// Honours AXI4_STREAM_FIFO_PKT_EN the same way as the design.
module tb_axi4_stream_fifo;
  import axi4_stream_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NRAND = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [4:0] cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit chk_en = 1'b0;

  axis_beat_t q[$];

  axi4_stream_if sti_if (.ACLK(clk), .ARESETn(rst_n));
  axi4_stream_if sto_if (.ACLK(clk), .ARESETn(rst_n));

  axi4_stream_fifo dut (
    .sti (sti_if),
    .sto (sto_if),
    .clr (clr),
    .cnt (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output is offered when non-empty; packet mode also needs a whole packet or a full buffer.
  function automatic bit model_valid();
`ifdef AXI4_STREAM_FIFO_PKT_EN
    int lasts = 0;
    foreach (q[i]) if (q[i].last) lasts++;
    return (q.size() != 0) && (lasts != 0 || q.size() == DEPTH);
`else
    return q.size() != 0;
`endif
  endfunction

  // Model state update from the stimulus the bench applied.
  always @(posedge clk) begin
    axis_beat_t b;
    bit do_push, do_pop;
    if (!rst_n || clr) begin
      q.delete();
    end else begin
      do_push = sti_if.TVALID && (q.size() != DEPTH);
      do_pop  = model_valid() && sto_if.TREADY;
      b.data = sti_if.TDATA;
      b.keep = sti_if.TKEEP;
      b.last = sti_if.TLAST;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(b);
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = model_valid();
      check("tvalid", 32'(sto_if.TVALID), 32'(ev));
      check("cnt", 32'(cnt), 32'(q.size()));
      check("tready", 32'(sti_if.TREADY), 32'(rst_n && (q.size() != DEPTH)));
      if (ev) begin
        check("tdata", 32'(sto_if.TDATA), 32'(q[0].data));
        check("tkeep", 32'(sto_if.TKEEP), 32'(q[0].keep));
        check("tlast", 32'(sto_if.TLAST), 32'(q[0].last));
      end else begin
        check("idle_zero", 32'({sto_if.TDATA, sto_if.TKEEP, sto_if.TLAST}), 32'(0));
      end
    end
  end

  // One clock: apply inputs, then return just after the following falling edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic k, input logic l,
                     input logic rdy, input logic c);
    sti_if.TVALID = v;
    sti_if.TDATA  = d;
    sti_if.TKEEP  = k;
    sti_if.TLAST  = l;
    sto_if.TREADY = rdy;
    clr           = c;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Terminate any open packet, then drain with a bounded budget.
  task automatic drain();
    int n = 0;
    cyc(1'b1, 8'h7F, 1'b1, 1'b1, 1'b1, 1'b0);
    while (q.size() != 0 && n < 64) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      n++;
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drain_cnt", 32'(cnt), 32'(0));
  endtask

  initial begin
    #(10 * 50000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sent, popped, budget;
    logic v, rdy;

    sti_if.TVALID = 1'b0;
    sti_if.TDATA  = '0;
    sti_if.TKEEP  = '0;
    sti_if.TLAST  = 1'b0;
    sto_if.TREADY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset state
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_cnt", 32'(cnt), 32'(0));
    check("rst_tvalid", 32'(sto_if.TVALID), 32'(0));
    check("rst_tready", 32'(sti_if.TREADY), 32'(1));

    // Fill with 0x00..0x0F while the sink stalls
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_cnt", 32'(cnt), 32'(16));
    check("full_tready", 32'(sti_if.TREADY), 32'(0));
    check("full_tvalid", 32'(sto_if.TVALID), 32'(1));
    check("full_head", 32'(sto_if.TDATA), 32'(8'h00));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_head", 32'(sto_if.TDATA), 32'(8'h00));

    // Pop from full with a concurrent offer: no push, one pop
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pop_cnt", 32'(cnt), 32'(15));
    check("pop_tready", 32'(sti_if.TREADY), 32'(1));
`ifdef AXI4_STREAM_FIFO_PKT_EN
    check("pop_tvalid", 32'(sto_if.TVALID), 32'(0));
`else
    check("pop_head", 32'(sto_if.TDATA), 32'(8'h01));
`endif
    drain();

    // Fall-through latency of one cycle
    cyc(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    check("ff_tvalid", 32'(sto_if.TVALID), 32'(1));
    check("ff_tdata", 32'(sto_if.TDATA), 32'(8'hA5));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ff_pop_cnt", 32'(cnt), 32'(0));

    // Flush beats a simultaneous push
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_clr_cnt", 32'(cnt), 32'(7));
    cyc(1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_cnt", 32'(cnt), 32'(0));
    check("clr_tvalid", 32'(sto_if.TVALID), 32'(0));
    check("clr_tready", 32'(sti_if.TREADY), 32'(1));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_no33", 32'(sto_if.TDATA), 32'(0));

    // Reset mid-packet
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(cnt), 32'(5));
    rst_n = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("inrst_tready", 32'(sti_if.TREADY), 32'(0));
    check("inrst_cnt", 32'(cnt), 32'(0));
    check("inrst_tvalid", 32'(sto_if.TVALID), 32'(0));
    check("inrst_tdata", 32'(sto_if.TDATA), 32'(0));
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("postrst_tready", 32'(sti_if.TREADY), 32'(1));

`ifdef AXI4_STREAM_FIFO_PKT_EN
    // Store-and-forward: held until TLAST arrives
    cyc(1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pkt_b1_tvalid", 32'(sto_if.TVALID), 32'(0));
    cyc(1'b1, 8'h82, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pkt_b2_tvalid", 32'(sto_if.TVALID), 32'(0));
    cyc(1'b1, 8'h83, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pkt_b3_tvalid", 32'(sto_if.TVALID), 32'(1));
    check("pkt_b3_head", 32'(sto_if.TDATA), 32'(8'h81));
    drain();

    // Oversize packet is released once the buffer is full
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h90 + i), 1'b1, 1'b0, 1'b0, 1'b0);
    check("big15_tvalid", 32'(sto_if.TVALID), 32'(0));
    cyc(1'b1, 8'h9F, 1'b1, 1'b0, 1'b0, 1'b0);
    check("big16_tvalid", 32'(sto_if.TVALID), 32'(1));
    check("big16_cnt", 32'(cnt), 32'(16));
    sent = 16;
    budget = 0;
    while (sent < 20 && budget < 100) begin
      v = 1'b1;
      if (sti_if.TREADY) sent++;
      cyc(v, 8'(8'h90 + sent - (sti_if.TREADY ? 1 : 0)), 1'b1, 1'(sent == 20), 1'b1, 1'b0);
      budget++;
    end
    check("big_sent", 32'(sent), 32'(20));
    drain();
`endif

    // Random back-pressure, ordered stream of NRAND beats
    sent = 0;
    popped = 0;
    budget = 0;
    while ((sent < NRAND || popped < NRAND) && budget < 20000) begin
      v   = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      sti_if.TVALID = v;
      sti_if.TDATA  = 8'(sent);
      sti_if.TKEEP  = 1'(sent >> 2);
      sti_if.TLAST  = 1'(sent % 4 == 3);
      if (sto_if.TVALID && rdy) begin
        check("rand_order", 32'(sto_if.TDATA), 32'(8'(popped)));
        popped++;
      end
      if (v && sti_if.TREADY) begin
        cyc(v, 8'(sent), 1'(sent >> 2), 1'(sent % 4 == 3), rdy, 1'b0);
        sent++;
      end else begin
        cyc(v, 8'(sent), 1'(sent >> 2), 1'(sent % 4 == 3), rdy, 1'b0);
      end
      budget++;
    end
    check("rand_sent", 32'(sent), 32'(NRAND));
    check("rand_popped", 32'(popped), 32'(NRAND));
    check("rand_end_cnt", 32'(cnt), 32'(0));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
